// File: rtl/sys_array_stream_ctrl.sv
// sys_array_stream_ctrl
// Stream front-end for a systolic-array fetcher. Collects a weight matrix W
// and a data matrix A from a single valid/ready input stream (row-major),
// strobes the fetcher to load weights and start the computation, captures the
// fetcher's result matrix and replays it row-major on a valid/ready output
// stream with an end-of-frame marker.
//
// Optional feature: define SYS_ARRAY_WEIGHT_REUSE_EN to add the keep_weights
// input, which lets a frame skip the weight phase when weights already loaded
// into the fetcher are still valid.
module sys_array_stream_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_W  = 4,
  parameter int ARRAY_A_L  = 4,
  parameter int ARRAY_W_W  = 4,
  parameter int ARRAY_W_L  = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
`ifdef SYS_ARRAY_WEIGHT_REUSE_EN
  input  logic                           keep_weights,
`endif
  input  logic                           s_valid,
  input  logic signed [DATA_WIDTH-1:0]   s_data,
  output logic                           s_ready,
  output logic                           m_valid,
  output logic signed [2*DATA_WIDTH-1:0] m_data,
  output logic                           m_last,
  input  logic                           m_ready,
  output logic                           weights_load,
  output logic                           start_comp,
  output logic signed [DATA_WIDTH-1:0]   input_data [ARRAY_A_W][ARRAY_A_L],
  output logic signed [DATA_WIDTH-1:0]   weights    [ARRAY_W_W][ARRAY_W_L],
  input  logic                           fetch_ready,
  input  logic signed [2*DATA_WIDTH-1:0] fetch_out  [ARRAY_A_W][ARRAY_W_L],
  output logic                           busy
);

  localparam int W_N  = ARRAY_W_W * ARRAY_W_L;
  localparam int A_N  = ARRAY_A_W * ARRAY_A_L;
  localparam int R_N  = ARRAY_A_W * ARRAY_W_L;
  localparam int W_CW = (W_N > 1) ? $clog2(W_N) : 1;
  localparam int A_CW = (A_N > 1) ? $clog2(A_N) : 1;
  localparam int R_CW = (R_N > 1) ? $clog2(R_N) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_W   = 3'd1;
  localparam logic [2:0] PULSE_WL = 3'd2;
  localparam logic [2:0] LOAD_A   = 3'd3;
  localparam logic [2:0] START    = 3'd4;
  localparam logic [2:0] WAIT     = 3'd5;
  localparam logic [2:0] DRAIN    = 3'd6;

  logic [2:0]      state, state_d;
  logic [W_CW-1:0] w_cnt, w_cnt_d;
  logic [A_CW-1:0] a_cnt, a_cnt_d;
  logic [R_CW-1:0] r_cnt, r_cnt_d;
  logic            w_beat, a_beat, res_latch;

  // Flat row-major storage; the matrix ports are views onto these.
  logic signed [DATA_WIDTH-1:0]   w_mem      [W_N];
  logic signed [DATA_WIDTH-1:0]   a_mem      [A_N];
  logic signed [2*DATA_WIDTH-1:0] res_buf    [R_N];
  logic signed [2*DATA_WIDTH-1:0] fetch_flat [R_N];

`ifdef SYS_ARRAY_WEIGHT_REUSE_EN
  logic w_valid;
`endif

  for (genvar r = 0; r < ARRAY_W_W; r++) begin : g_w_row
    for (genvar c = 0; c < ARRAY_W_L; c++) begin : g_w_col
      assign weights[r][c] = w_mem[r*ARRAY_W_L + c];
    end
  end

  for (genvar r = 0; r < ARRAY_A_W; r++) begin : g_a_row
    for (genvar c = 0; c < ARRAY_A_L; c++) begin : g_a_col
      assign input_data[r][c] = a_mem[r*ARRAY_A_L + c];
    end
  end

  for (genvar r = 0; r < ARRAY_A_W; r++) begin : g_f_row
    for (genvar c = 0; c < ARRAY_W_L; c++) begin : g_f_col
      assign fetch_flat[r*ARRAY_W_L + c] = fetch_out[r][c];
    end
  end

  // Result element is a mux off registered state, so it holds while stalled.
  assign m_data = m_valid ? res_buf[r_cnt] : '0;

  // Next-state and counter logic; counters return to zero on every exit.
  always_comb begin
    state_d   = state;
    w_cnt_d   = w_cnt;
    a_cnt_d   = a_cnt;
    r_cnt_d   = r_cnt;
    w_beat    = 1'b0;
    a_beat    = 1'b0;
    res_latch = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
`ifdef SYS_ARRAY_WEIGHT_REUSE_EN
          state_d = (keep_weights && w_valid) ? LOAD_A : LOAD_W;
`else
          state_d = LOAD_W;
`endif
        end
      end
      LOAD_W: begin
        if (s_valid && s_ready) begin
          w_beat = 1'b1;
          if (w_cnt == W_CW'(W_N - 1)) begin
            w_cnt_d = '0;
            state_d = PULSE_WL;
          end else begin
            w_cnt_d = w_cnt + 1'b1;
          end
        end
      end
      PULSE_WL: state_d = LOAD_A;
      LOAD_A: begin
        if (s_valid && s_ready) begin
          a_beat = 1'b1;
          if (a_cnt == A_CW'(A_N - 1)) begin
            a_cnt_d = '0;
            state_d = START;
          end else begin
            a_cnt_d = a_cnt + 1'b1;
          end
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (fetch_ready) begin
          res_latch = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (m_valid && m_ready) begin
          if (r_cnt == R_CW'(R_N - 1)) begin
            r_cnt_d = '0;
            state_d = IDLE;
          end else begin
            r_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered state decodes for the handshake/strobe outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      w_cnt        <= '0;
      a_cnt        <= '0;
      r_cnt        <= '0;
      s_ready      <= 1'b0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      weights_load <= 1'b0;
      start_comp   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      w_cnt        <= w_cnt_d;
      a_cnt        <= a_cnt_d;
      r_cnt        <= r_cnt_d;
      s_ready      <= (state_d == LOAD_W) || (state_d == LOAD_A);
      m_valid      <= (state_d == DRAIN);
      m_last       <= (state_d == DRAIN) && (r_cnt_d == R_CW'(R_N - 1));
      weights_load <= (state_d == PULSE_WL);
      start_comp   <= (state_d == START);
      busy         <= (state_d != IDLE);
    end
  end

  // Matrix storage and result capture; matrices hold until overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < W_N; i++) w_mem[i] <= '0;
      for (int i = 0; i < A_N; i++) a_mem[i] <= '0;
      for (int i = 0; i < R_N; i++) res_buf[i] <= '0;
    end else begin
      if (w_beat) w_mem[w_cnt] <= s_data;
      if (a_beat) a_mem[a_cnt] <= s_data;
      if (res_latch) begin
        for (int i = 0; i < R_N; i++) res_buf[i] <= fetch_flat[i];
      end
    end
  end

`ifdef SYS_ARRAY_WEIGHT_REUSE_EN
  // Remembers that the fetcher holds a loaded weight set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_valid <= 1'b0;
    end else if (state == PULSE_WL) begin
      w_valid <= 1'b1;
    end
  end
`endif

endmodule
